// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word request at a time to instruction memory
// and holds the returned instruction for IF/ID until it is consumed or redirected.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] Instruction,
  output logic        InstrValid
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] pending_target;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target  = BranchTarget & 32'hFFFF_FFFC;
  assign pc_inc  = PC + 32'd4;

  // PC only moves when leaving REQ/DROP, so the request address stays put until the ack edge
  assign IMemReq  = (state == REQ) || (state == DROP);
  assign IMemAddr = {PC[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      PC             <= RESET_PC;
      PCPlus4        <= '0;
      Instruction    <= '0;
      InstrValid     <= 1'b0;
      pending_target <= '0;
    end else begin
      unique case (state)
        IDLE: state <= REQ;

        REQ: begin
          if (IMemAck) begin
            if (PCSrc) begin
              PC <= target;
            end else begin
              Instruction <= IMemData;
              PCPlus4     <= pc_inc;
              InstrValid  <= 1'b1;
              state       <= VALID;
            end
          end else if (PCSrc) begin
            pending_target <= target;
            state          <= DROP;
          end
        end

        // Wait out the abandoned request; the newest redirect wins
        DROP: begin
          if (IMemAck) begin
            PC    <= PCSrc ? target : pending_target;
            state <= REQ;
          end else if (PCSrc) begin
            pending_target <= target;
          end
        end

        VALID: begin
          if (PCSrc) begin
            InstrValid <= 1'b0;
            PC         <= target;
            state      <= REQ;
          end else if (PCWrite) begin
            InstrValid <= 1'b0;
            PC         <= pc_inc;
            state      <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-low reset (0 = reset asserted).
REQ-005 PCWrite  in  1  hazard-unit enable; 0 = hold current fetched instruction.
REQ-006 PCSrc  in  1  redirect request (taken branch/jump), sampled each rising edge.
REQ-007 BranchTarget  in  32  redirect address; bits [1:0] ignored and treated as 0.
REQ-008 IMemReq  out  1  instruction-memory request.
REQ-009 IMemAddr  out  32  word address of the outstanding request, bits [1:0] = 0.
REQ-010 IMemAck  in  1  memory completion; IMemData valid in the same cycle.
REQ-011 IMemData  in  32  instruction word returned by memory.
REQ-012 PC  out  32  current fetch address register.
REQ-013 PCPlus4  out  32  registered PC+4 of the held instruction, to IF/ID.
REQ-014 Instruction  out  32  registered fetched instruction, to IF/ID.
REQ-015 InstrValid  out  1  Instruction/PCPlus4 hold a valid, undiscarded fetch.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, VALID and DROP, with IMemReq = 1 exactly in REQ and DROP.
REQ-017 IMemAddr SHALL equal PC in REQ and SHALL stay stable from request assertion until the edge at which IMemAck = 1 is sampled.
REQ-018 IDLE SHALL go to REQ on the first rising edge after rst deasserts; no other IDLE exit exists.
REQ-019 REQ, IMemAck = 1, PCSrc = 0: Instruction <= IMemData, PCPlus4 <= PC + 4, InstrValid <= 1, go to VALID; this is a 1-cycle ack-to-output latency.
REQ-020 REQ, IMemAck = 1, PCSrc = 1: IMemData discarded, PC <= {BranchTarget[31:2], 2'b00}, stay in REQ, so the new request is issued the next cycle.
REQ-021 REQ, IMemAck = 0, PCSrc = 1: the target SHALL be latched into an internal pending register and the FSM SHALL go to DROP, with PC unchanged.
REQ-022 REQ, IMemAck = 0, PCSrc = 0: stay in REQ with all registers unchanged.
REQ-023 DROP SHALL keep the original request asserted; PCSrc = 1 in DROP overwrites the pending target with the newest target.
REQ-024 DROP with IMemAck = 1: data discarded, PC <= pending target (or the current BranchTarget if PCSrc = 1 that cycle), InstrValid stays 0, go to REQ.
REQ-025 VALID, PCSrc = 1: InstrValid <= 0, PC <= target, go to REQ, regardless of PCWrite (redirect has priority over stall).
REQ-026 VALID, PCSrc = 0, PCWrite = 1: the instruction is consumed at this edge, so InstrValid <= 0, PC <= PC + 4, go to REQ.
REQ-027 VALID, PCSrc = 0, PCWrite = 0: hold PC, PCPlus4, Instruction, InstrValid = 1 unchanged.
REQ-028 PCWrite SHALL have no effect in IDLE, REQ or DROP.
REQ-029 InstrValid SHALL be 1 only in VALID.
REQ-030 PC + 4 and PCPlus4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-031 IMemAck while IMemReq = 0 SHALL be ignored.
REQ-032 At most one request SHALL ever be outstanding.

Reset
REQ-033 rst = 0 SHALL immediately, independent of clk, force state = IDLE, PC = RESET_PC, PCPlus4 = 0, Instruction = 0, InstrValid = 0 and IMemReq = 0.
REQ-034 The pending-target register SHALL reset to 0.
REQ-035 Reset asserted mid-request SHALL abandon the request with no data captured, and the first post-reset request SHALL use RESET_PC.

Verification
REQ-036 Straight-line: RESET_PC = 0, ack 1 cycle after each req, PCWrite = 1 -> IMemAddr sequence 0, 4, 8; Instruction matches data; PCPlus4 = 4, 8, 12.
REQ-037 Stall: in VALID with Instruction = 32'h0000_0013, hold PCWrite = 0 for 3 cycles -> outputs constant, IMemReq = 0, PC = 0; release -> IMemAddr = 4.
REQ-038 Redirect while waiting: req at 8, PCSrc = 1 with target 32'h100 before ack, ack 2 cycles later with data 32'hDEAD_BEEF -> DEAD_BEEF never valid; next IMemAddr = 32'h100.
REQ-039 Redirect coincident with ack, and redirect in VALID with PCWrite = 0 -> data dropped, InstrValid = 0, next IMemAddr = target.
REQ-040 Wrap: RESET_PC = 32'hFFFF_FFFC -> PCPlus4 = 0; next IMemAddr = 0.
REQ-041 Reset mid-request: rst low while in DROP -> all outputs at reset values immediately; after release, first IMemAddr = RESET_PC.
